// File: rtl/data_bus_arbiter.sv
// Shares the single-port data RAM between the CPU data port and one auxiliary
// requester. The CPU wins by default; aux gets idle CPU cycles or a forced slot.
module data_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [7:0]            aux_wdata,
    output logic                  aux_gnt,
    output logic                  aux_rvalid,
    output logic [7:0]            aux_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    // A limit of 0 still needs a 1-bit counter; it simply sits at 0 and forces every slot.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starveCnt;
    logic             r_auxRvalid;
    logic             w_cpuAct;
    logic             w_force;
    logic             w_auxSel;

    assign w_cpuAct = cpu_ren | cpu_wen;
    assign w_force  = (r_starveCnt == LIMIT);
    assign w_auxSel = !reset && aux_req && (!w_cpuAct || w_force);

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_ren   = cpu_ren;
        mem_wen   = cpu_wen;
        aux_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (w_auxSel) begin
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            mem_ren   = !aux_we;
            mem_wen   = aux_we;
            aux_gnt   = 1'b1;
            cpu_stall = w_cpuAct;
        end
        if (reset) begin
            mem_ren = 1'b0;
            mem_wen = 1'b0;
        end
    end

    // Counter only climbs while strictly below the limit, so it never overshoots.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starveCnt <= '0;
            r_auxRvalid <= 1'b0;
        end else begin
            r_auxRvalid <= w_auxSel & !aux_we;
            if (w_auxSel) begin
                r_starveCnt <= '0;
            end else if (aux_req && w_cpuAct && !w_force) begin
                r_starveCnt <= r_starveCnt + CNT_W'(1);
            end else if (!aux_req) begin
                r_starveCnt <= '0;
            end
        end
    end

    assign aux_rvalid = r_auxRvalid;
    assign aux_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: one DUT with the default starvation
// limit and one with limit 0, each in front of a small synchronous RAM model.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpuAddr;
    logic        cpuRen;
    logic        cpuWen;
    logic [7:0]  cpuWdata;
    logic        auxReq;
    logic        auxWe;
    logic [15:0] auxAddr;
    logic [7:0]  auxWdata;

    logic [7:0]  cpuRdataA, auxRdataA, memWdataA, memRdataA;
    logic        cpuStallA, auxGntA, auxRvalidA, memRenA, memWenA;
    logic [15:0] memAddrA;
    logic [7:0]  cpuRdataB, auxRdataB, memWdataB, memRdataB;
    logic        cpuStallB, auxGntB, auxRvalidB, memRenB, memWenB;
    logic [15:0] memAddrB;

    logic [7:0]  ramA [256];
    logic [7:0]  ramB [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.ADDR_WIDTH(16), .STARVE_LIMIT(4)) dutA (
        .clk(clk), .reset(reset),
        .cpu_addr(cpuAddr), .cpu_ren(cpuRen), .cpu_wen(cpuWen), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdataA), .cpu_stall(cpuStallA),
        .aux_req(auxReq), .aux_we(auxWe), .aux_addr(auxAddr), .aux_wdata(auxWdata),
        .aux_gnt(auxGntA), .aux_rvalid(auxRvalidA), .aux_rdata(auxRdataA),
        .mem_addr(memAddrA), .mem_ren(memRenA), .mem_wen(memWenA),
        .mem_wdata(memWdataA), .mem_rdata(memRdataA)
    );

    data_bus_arbiter #(.ADDR_WIDTH(16), .STARVE_LIMIT(0)) dutB (
        .clk(clk), .reset(reset),
        .cpu_addr(cpuAddr), .cpu_ren(cpuRen), .cpu_wen(cpuWen), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdataB), .cpu_stall(cpuStallB),
        .aux_req(auxReq), .aux_we(auxWe), .aux_addr(auxAddr), .aux_wdata(auxWdata),
        .aux_gnt(auxGntB), .aux_rvalid(auxRvalidB), .aux_rdata(auxRdataB),
        .mem_addr(memAddrB), .mem_ren(memRenB), .mem_wen(memWenB),
        .mem_wdata(memWdataB), .mem_rdata(memRdataB)
    );

    // Synchronous-read RAMs: output register holds its value when not reading.
    always @(posedge clk) begin
        if (memWenA) ramA[memAddrA[7:0]] <= memWdataA;
        if (memRenA) memRdataA <= ramA[memAddrA[7:0]];
        if (memWenB) ramB[memAddrB[7:0]] <= memWdataB;
        if (memRenB) memRdataB <= ramB[memAddrB[7:0]];
    end

    // Drive one cycle's inputs just after the edge, then wait to the mid-cycle sample point.
    task automatic applyStimulus(input logic rst,
                                 input logic [15:0] cA, input logic cR, input logic cW, input logic [7:0] cD,
                                 input logic aR, input logic aW, input logic [15:0] aA, input logic [7:0] aD);
        reset    = rst;
        cpuAddr  = cA;
        cpuRen   = cR;
        cpuWen   = cW;
        cpuWdata = cD;
        auxReq   = aR;
        auxWe    = aW;
        auxAddr  = aA;
        auxWdata = aD;
        #4;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nextCycle();
        // Reset with both masters active: everything must be gated off
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
        checkOutput("rst_gnt", 32'(auxGntA), 32'h0);
        checkOutput("rst_stall", 32'(cpuStallA), 32'h0);
        checkOutput("rst_ren", 32'(memRenA), 32'h0);
        checkOutput("rst_wen", 32'(memWenA), 32'h0);
        checkOutput("rst_addr", 32'(memAddrA), 32'h0010);
        nextCycle();
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("rst_rvalid", 32'(auxRvalidA), 32'h0);
        nextCycle();

        $display("[TB] CPU write then read");
        applyStimulus(1'b0, 16'h0010, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t1_wen", 32'(memWenA), 32'h1);
        checkOutput("t1_wdata", 32'(memWdataA), 32'h5A);
        checkOutput("t1_addr", 32'(memAddrA), 32'h0010);
        checkOutput("t1_stall_w", 32'(cpuStallA), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t1_ren", 32'(memRenA), 32'h1);
        checkOutput("t1_stall_r", 32'(cpuStallA), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t1_rdata", 32'(cpuRdataA), 32'h5A);
        nextCycle();

        $display("[TB] aux on idle CPU");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0020, 8'hC3);
        checkOutput("t2_gnt_w", 32'(auxGntA), 32'h1);
        checkOutput("t2_wen", 32'(memWenA), 32'h1);
        checkOutput("t2_ren_w", 32'(memRenA), 32'h0);
        checkOutput("t2_addr", 32'(memAddrA), 32'h0020);
        checkOutput("t2_wdata", 32'(memWdataA), 32'hC3);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
        checkOutput("t2_gnt_r", 32'(auxGntA), 32'h1);
        checkOutput("t2_ren_r", 32'(memRenA), 32'h1);
        checkOutput("t2_wen_r", 32'(memWenA), 32'h0);
        checkOutput("t2_rvalid_early", 32'(auxRvalidA), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t2_rvalid", 32'(auxRvalidA), 32'h1);
        checkOutput("t2_rdata", 32'(auxRdataA), 32'hC3);
        checkOutput("t2_gnt_idle", 32'(auxGntA), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t2_rvalid_drop", 32'(auxRvalidA), 32'h0);
        nextCycle();

        $display("[TB] starvation pattern and read ordering");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
            checkOutput($sformatf("t3_gnt_%0d", i), 32'(auxGntA), 32'((i % 5) == 4));
            checkOutput($sformatf("t3_stall_%0d", i), 32'(cpuStallA), 32'((i % 5) == 4));
            checkOutput($sformatf("t3_rvalid_%0d", i), 32'(auxRvalidA), 32'((i % 5) == 0 && i > 0));
            if ((i % 5) == 4) begin
                checkOutput($sformatf("t6_cpu_rdata_%0d", i), 32'(cpuRdataA), 32'h5A);
                checkOutput($sformatf("t3_addr_%0d", i), 32'(memAddrA), 32'h0020);
            end
            if (i == 5) checkOutput("t6_aux_rdata", 32'(auxRdataA), 32'hC3);
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        nextCycle();

        $display("[TB] reset after aux read grant");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
            checkOutput($sformatf("t5_pre_gnt_%0d", i), 32'(auxGntA), 32'h0);
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
        checkOutput("t5_gnt_N", 32'(auxGntA), 32'h1);
        nextCycle();
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
        checkOutput("t5_rvalid_N1", 32'(auxRvalidA), 32'h1);
        checkOutput("t5_gnt_N1", 32'(auxGntA), 32'h0);
        checkOutput("t5_ren_N1", 32'(memRenA), 32'h0);
        checkOutput("t5_wen_N1", 32'(memWenA), 32'h0);
        checkOutput("t5_stall_N1", 32'(cpuStallA), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
        checkOutput("t5_rvalid_N2", 32'(auxRvalidA), 32'h0);
        nextCycle();

        // Counter built to 3, then reset: full 4 blocked cycles must be needed again
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
            nextCycle();
        end
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
        checkOutput("t5_gnt_rst", 32'(auxGntA), 32'h0);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
            checkOutput($sformatf("t5_cnt_clear_%0d", i), 32'(auxGntA), 32'(i == 4));
            nextCycle();
        end

        $display("[TB] strict aux priority (limit 0)");
        applyStimulus(1'b0, 16'h0040, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 16'h0040, 8'h77);
        checkOutput("t4_gnt_0", 32'(auxGntB), 32'h1);
        checkOutput("t4_stall_0", 32'(cpuStallB), 32'h1);
        checkOutput("t4_wdata_0", 32'(memWdataB), 32'h77);
        checkOutput("t4_ren_0", 32'(memRenB), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0040, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 16'h0040, 8'h00);
        checkOutput("t4_gnt_1", 32'(auxGntB), 32'h1);
        checkOutput("t4_stall_1", 32'(cpuStallB), 32'h1);
        checkOutput("t4_wen_1", 32'(memWenB), 32'h0);
        checkOutput("t4_ren_1", 32'(memRenB), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 16'h0040, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0040, 8'h00);
        checkOutput("t4_gnt_2", 32'(auxGntB), 32'h1);
        checkOutput("t4_stall_2", 32'(cpuStallB), 32'h1);
        checkOutput("t4_rvalid_2", 32'(auxRvalidB), 32'h1);
        checkOutput("t4_rdata_2", 32'(auxRdataB), 32'h77);
        nextCycle();

        $display("[TB] address pass-through and simultaneous strobes");
        applyStimulus(1'b0, 16'h1234, 1'b0, 1'b0, 8'hAB, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("pt_rdata_B", 32'(auxRdataB), 32'h77);
        checkOutput("pt_addr", 32'(memAddrA), 32'h1234);
        checkOutput("pt_wdata", 32'(memWdataA), 32'hAB);
        checkOutput("pt_ren", 32'(memRenA), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0050, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("both_ren", 32'(memRenA), 32'h1);
        checkOutput("both_wen", 32'(memWenA), 32'h1);
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
